// File: rtl/quad_step_decoder_pkg.sv
// Shared types and constants for the quadrature step decoder.
package quad_step_decoder_pkg;

    localparam int unsigned FILT_LEN_DEF = 4;
    localparam int unsigned FILT_LEN_MIN = 1;
    localparam int unsigned FILT_LEN_MAX = 16;
    localparam int unsigned FILT_CNT_W   = 4;
    // Settle counter must reach FILT_LEN_MAX+1 = 17.
    localparam int unsigned SETTLE_W     = 5;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Phase constants, {A,B}.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Position of a phase along the up sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ph);
        logic [1:0] pos;
        pos = 2'd0;
        case (ph)
            PH_00:   pos = 2'd0;
            PH_10:   pos = 2'd1;
            PH_11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder phase: 2-flop synchronizer followed by a FILT_LEN glitch filter.
module quad_chan_filter
    import quad_step_decoder_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic load,
    output logic filt
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic                  sync1;
    logic                  sync2;
    logic [FILT_CNT_W-1:0] cnt;

    // Bring the asynchronous phase into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            filt <= sync2;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + FILT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: filters both phases and emits U/D/err step pulses.
module quad_step_decoder
    import quad_step_decoder_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    input  logic enable,
    output logic U,
    output logic D,
    output logic err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(FILT_LEN + 1);

    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle;
    logic [SETTLE_W-1:0] settle_nxt;
    logic                load_c;
    logic                filt_a;
    logic                filt_b;
    logic [1:0]          prev;
    logic [1:0]          delta_c;
    logic                u_nxt;
    logic                d_nxt;
    logic                err_nxt;

    quad_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .raw   (a_in),
        .load  (load_c),
        .filt  (filt_a)
    );

    quad_chan_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .raw   (b_in),
        .load  (load_c),
        .filt  (filt_b)
    );

    // Next state, settle count and step decode of the filtered phase movement.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle;
        load_c     = 1'b0;
        u_nxt      = 1'b0;
        d_nxt      = 1'b0;
        err_nxt    = 1'b0;
        // Distance moved along the up sequence: 1 = up, 3 = down, 2 = skipped.
        delta_c    = gray_pos({filt_a, filt_b}) - gray_pos(prev);
        case (state)
            INIT: begin
                load_c = 1'b1;
                if (settle == SETTLE_LAST) begin
                    state_nxt  = TRACK;
                    settle_nxt = '0;
                end else begin
                    settle_nxt = settle + SETTLE_W'(1);
                end
            end
            TRACK: begin
                if (enable) begin
                    case (delta_c)
                        2'd1:    u_nxt   = 1'b1;
                        2'd3:    d_nxt   = 1'b1;
                        2'd2:    err_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // State register and settle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= INIT;
            settle <= '0;
        end else begin
            state  <= state_nxt;
            settle <= settle_nxt;
        end
    end

    // Previous filtered pair and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= PH_00;
            U    <= 1'b0;
            D    <= 1'b0;
            err  <= 1'b0;
        end else begin
            prev <= {filt_a, filt_b};
            U    <= u_nxt;
            D    <= d_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: vector table, corner sequences, random run.
module tb_quad_step_decoder;
    import quad_step_decoder_pkg::*;

    localparam int unsigned FL  = 4;
    localparam int          FLI = 4;
    localparam logic [1:0] RING [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic a_in   = 1'b0;
    logic b_in   = 1'b0;
    logic enable = 1'b1;
    logic u, d, err;

    quad_step_decoder #(.FILT_LEN(FL)) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .enable (enable),
        .U      (u),
        .D      (d),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_u, n_d, n_e;

    // Reference model: raw sample history and filtered phase history.
    int         m_n;
    bit         m_sa[$];
    bit         m_sb[$];
    logic [1:0] m_filt;
    logic [1:0] m_old;
    logic       m_u, m_d, m_e;

    typedef struct {
        logic [1:0] ph;
        int         hold;
        bit         en;
        int         eu;
        int         ed;
        int         ee;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ring_pos(input logic [1:0] ph);
        for (int i = 0; i < 4; i++) if (RING[i] == ph) return i;
        return 0;
    endfunction

    // A level is accepted once the last FILT_LEN synchronized samples all disagree with it.
    function automatic bit flips(input bit q[$], input bit cur);
        if (q.size() < FLI + 2) return 1'b0;
        for (int j = 2; j <= FLI + 1; j++) if (q[j] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_sa.delete();
        m_sb.delete();
        m_filt = 2'b00;
        m_old  = 2'b00;
        m_u = 1'b0; m_d = 1'b0; m_e = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] nf;
        bit sa2, sb2;
        int diff;
        m_n++;
        m_sa.push_front(a_in);
        m_sb.push_front(b_in);
        sa2 = (m_sa.size() > 2) ? m_sa[2] : 1'b0;
        sb2 = (m_sb.size() > 2) ? m_sb[2] : 1'b0;
        m_u = 1'b0; m_d = 1'b0; m_e = 1'b0;
        if (m_n >= FLI + 3 && enable) begin
            diff = (ring_pos(m_filt) - ring_pos(m_old) + 4) % 4;
            m_u = (diff == 1);
            m_d = (diff == 3);
            m_e = (diff == 2);
        end
        if (m_n <= FLI + 2) begin
            nf = {sa2, sb2};
        end else begin
            nf[1] = flips(m_sa, m_filt[1]) ? ~m_filt[1] : m_filt[1];
            nf[0] = flips(m_sb, m_filt[0]) ? ~m_filt[0] : m_filt[0];
        end
        m_old  = m_filt;
        m_filt = nf;
        while (m_sa.size() > FLI + 2) void'(m_sa.pop_back());
        while (m_sb.size() > FLI + 2) void'(m_sb.pop_back());
    endtask

    // One clock: update model on the edge, compare 1 time unit later, return at negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        #1;
        check("outputs_udE", int'({u, d, err}), int'({m_u, m_d, m_e}));
        check("u_d_exclusive", int'(u & d), 0);
        n_u += int'(u);
        n_d += int'(d);
        n_e += int'(err);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        n_u = 0; n_d = 0; n_e = 0;
    endtask

    task automatic do_reset(input logic [1:0] ph);
        reset = 1'b0;
        a_in  = ph[1];
        b_in  = ph[0];
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic hold(input logic [1:0] ph, input int cycles, input bit en);
        a_in   = ph[1];
        b_in   = ph[0];
        enable = en;
        repeat (cycles) tick();
    endtask

    initial begin
        int first_u;
        bit seen;
        logic [1:0] cur;
        int r, dur;

        clear_counts();
        tbl[0]  = '{2'b00, 10, 1'b1, 0, 0, 0};
        tbl[1]  = '{2'b10, 10, 1'b1, 1, 0, 0};
        tbl[2]  = '{2'b11, 10, 1'b1, 1, 0, 0};
        tbl[3]  = '{2'b01, 10, 1'b1, 1, 0, 0};
        tbl[4]  = '{2'b00, 10, 1'b1, 1, 0, 0};
        tbl[5]  = '{2'b01, 10, 1'b1, 0, 1, 0};
        tbl[6]  = '{2'b11, 10, 1'b1, 0, 1, 0};
        tbl[7]  = '{2'b10, 10, 1'b1, 0, 1, 0};
        tbl[8]  = '{2'b00, 10, 1'b1, 0, 1, 0};
        tbl[9]  = '{2'b11, 10, 1'b1, 0, 0, 1};
        tbl[10] = '{2'b01, 10, 1'b1, 1, 0, 0};
        tbl[11] = '{2'b00, 10, 1'b1, 1, 0, 0};
        tbl[12] = '{2'b10, 10, 1'b1, 1, 0, 0};
        tbl[13] = '{2'b00, 10, 1'b1, 0, 1, 0};
        tbl[14] = '{2'b10, 10, 1'b0, 0, 0, 0};
        tbl[15] = '{2'b11, 10, 1'b0, 0, 0, 0};
        tbl[16] = '{2'b01, 10, 1'b1, 1, 0, 0};
        tbl[17] = '{2'b00, 10, 1'b1, 1, 0, 0};

        // Reset release resting at 11: INIT for FILT_LEN+2 edges, no pulses.
        do_reset(2'b11);
        clear_counts();
        for (int i = 0; i < FLI + 1; i++) begin
            tick();
            check("state_init", int'(dut.state), int'(INIT));
        end
        tick();
        check("state_track", int'(dut.state), int'(TRACK));
        repeat (6) tick();
        check("filt_after_reset", int'({dut.filt_a, dut.filt_b}), 3);
        check("reset_rest_pulses", n_u + n_d + n_e, 0);

        // End-to-end latency of a clean a_in edge from rest at 00.
        do_reset(2'b00);
        hold(2'b00, 12, 1'b1);
        clear_counts();
        a_in = 1'b1;
        first_u = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (u && first_u < 0) first_u = i;
        end
        check("latency_edges", first_u, FLI + 2);
        check("latency_pulse_count", n_u, 1);
        hold(2'b00, 10, 1'b1);

        // Vector table: one phase per row, pulse counts per row.
        for (int i = 0; i < 18; i++) begin
            clear_counts();
            hold(tbl[i].ph, tbl[i].hold, tbl[i].en);
            check($sformatf("tbl%0d_U", i), n_u, tbl[i].eu);
            check($sformatf("tbl%0d_D", i), n_d, tbl[i].ed);
            check($sformatf("tbl%0d_err", i), n_e, tbl[i].ee);
        end

        // Glitch one cycle shorter than the filter is rejected.
        clear_counts();
        hold(2'b10, FLI - 1, 1'b1);
        hold(2'b00, 12, 1'b1);
        check("glitch_short_pulses", n_u + n_d + n_e, 0);
        check("glitch_short_filt", int'(dut.filt_a), 0);

        // Glitch exactly FILT_LEN long is accepted, and the return is a down step.
        clear_counts();
        hold(2'b10, FLI, 1'b1);
        hold(2'b00, 12, 1'b1);
        check("glitch_long_U", n_u, 1);
        check("glitch_long_D", n_d, 1);

        // Reset while U is high drops it asynchronously.
        a_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (u) seen = 1'b1;
        end
        check("midpulse_u_seen", int'(seen), 1);
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_async_U", int'(u), 0);
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b1;
        clear_counts();
        hold(2'b10, 20, 1'b1);
        check("post_reset_rest_10", n_u + n_d + n_e, 0);

        // Random phase activity including glitches, skips and enable toggles.
        cur = 2'b10;
        for (int s = 0; s < 400; s++) begin
            r   = int'($urandom_range(0, 9));
            dur = int'($urandom_range(1, FL + 7));
            if (r <= 5) begin
                cur = RING[(ring_pos(cur) + ((r < 3) ? 1 : 3)) % 4];
                hold(cur, dur, enable);
            end else if (r == 6) begin
                cur = RING[(ring_pos(cur) + 2) % 4];
                hold(cur, dur, enable);
            end else if (r == 7) begin
                hold(cur ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01),
                     int'($urandom_range(1, FL)), enable);
                hold(cur, dur, enable);
            end else if (r == 8) begin
                hold(cur, dur, ~enable);
            end else begin
                hold(cur, dur, enable);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage of the 3-bit up/down counter. Converts raw two-phase quadrature signals from a rotary encoder into the counter's step commands.
- Synchronizes and glitch-filters both phases, then tracks the Gray-code phase with a state machine.
- Emits mutually exclusive one-cycle U / D pulses for each legal step, and an err pulse when a step is skipped.
- Outputs connect directly to the counter's U and D inputs on the same clk.

Parameters:
- FILT_LEN, 4: consecutive cycles a synchronized phase must hold a new value before it is accepted. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; resets all state.
- a_in  input  1  encoder phase A, asynchronous to clk.
- b_in  input  1  encoder phase B, asynchronous to clk.
- enable  input  1  high = pulses allowed; low = tracking only.
- U  output  1  one-cycle up-step pulse.
- D  output  1  one-cycle down-step pulse.
- err  output  1  one-cycle pulse on an illegal double-phase change.

Behaviour:
- Reset (reset low, asynchronous):
  - sync flops, filtered phases, filter counters, settle counter, U, D, err all 0.
  - FSM enters INIT.
- Synchronizer: each phase passes through two flops; sync2 is the second-flop output.
- Filter (per phase, in TRACK):
  - If sync2 == filt, the counter clears.
  - Otherwise the counter increments. When sync2 != filt at counter == FILT_LEN-1, filt <= sync2 and the counter clears.
  - filt therefore updates on the FILT_LEN-th consecutive differing edge.
  - Any bounce back to filt before that point clears the counter; the pulse is rejected.
- FSM states:
  - INIT: filt loads sync2 directly every cycle, no pulses. A settle counter runs FILT_LEN+2 cycles after reset release, then the FSM moves to TRACK.
  - TRACK: filtered phases are compared with the previous filtered pair prev={A,B}, registered each cycle.
- Step decode in TRACK (registered, asserted the cycle after filt changes):
  - Up sequence {A,B}: 00->10->11->01->00. A legal up transition gives U=1 for one cycle.
  - Down sequence: 00->01->11->10->00. A legal down transition gives D=1 for one cycle.
  - Both bits changing in the same cycle (00<->11, 10<->01) gives err=1, no U/D, and prev takes the new value.
  - No change gives U=D=err=0.
- End-to-end latency: a clean edge on a_in first sampled at edge k produces U/D high after edge k+FILT_LEN+2, lasting one cycle. FILT_LEN=4 gives 6 edges.
- Invariants:
  - U and D are never high together.
  - At most one pulse per filtered transition.
  - Maximum step rate is one per FILT_LEN+1 cycles per phase.
- enable low: filter and prev keep tracking; U, D and err are forced 0. Re-enabling does not replay missed steps.
- reset asserted mid-operation: all outputs drop to 0 immediately; the block restarts in INIT.
  - An encoder resting at any phase after reset produces no spurious U, D or err.
- Direction reversal (e.g. 10->00 immediately after 00->10) is legal: the first transition gives U, the second gives D.

Decomposition:
- Shared package:
  - FSM state encoding: INIT, TRACK.
  - Phase constants: PH_00, PH_10, PH_11, PH_01.
  - FILT_LEN default and legal-range limits.
  - Filter counter width: 4 bits, enough for 16.
- Sub-module quad_chan_filter: 2-flop synchronizer plus FILT_LEN glitch filter, with a load-direct input used in INIT. Instantiated once per phase.

Test Plan:
- Reset release with a_in=1, b_in=1 held, FILT_LEN=4 -> INIT for 6 cycles; U=D=err=0 throughout; filt={1,1}.
- From rest at 00, drive the up sequence 10,11,01,00 with each phase held 10 cycles -> exactly 4 U pulses, each 1 cycle wide, the first 6 edges after a_in rises; D=err=0.
- From rest at 00, drive the down sequence 01,11,10,00 -> exactly 4 D pulses; U=err=0. Chained into the 3-bit counter, the count goes 0->4 on the up run, then back to 0 on this down run.
- Glitch on a_in high for 3 cycles then back, FILT_LEN=4 -> no pulse, filt unchanged. The same glitch held 4 cycles -> one U pulse.
- Change a_in and b_in in the same cycle, 00->11 -> err=1 for one cycle, U=D=0. A following 11->01 step gives a U pulse.
- enable=0 during two up steps, then enable=1 and one more up step -> a single U pulse. Assert reset mid-pulse -> U drops to 0 asynchronously.
